// File: rtl/seq_unlock_pkg.sv
// Purpose : shared state encoding and default sizes for the sequence unlock matcher.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package seq_unlock_pkg;

    localparam int DEF_W       = 8;
    localparam int DEF_MAX_LEN = 64;
    localparam int DEF_FAIL_W  = 8;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_SOLVED   = 2'd2,
        ST_LOCKED   = 2'd3
    } state_e;

endpackage

// File: rtl/seq_unlock_pattern_mem.sv
// Purpose : MAX_LEN x W pattern register file, one write port, two combinational read ports.
// Latency : write visible on the read ports the cycle after the write strobe; reads are combinational.
// Backpressure: none; every write strobe is accepted.
//
// Ports: clk/rst_n (sync active-low, clears every entry), we/wr_addr/wr_data (write,
// addresses >= MAX_LEN ignored), rd_addr/rd_data (indexed read, 0 when out of range),
// rd0_data (entry 0, used for resync).
module seq_unlock_pattern_mem
    import seq_unlock_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int IDX_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [W-1:0]     wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [W-1:0]     rd_data,
    output logic [W-1:0]     rd0_data
);

    localparam int               AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [IDX_W-1:0] DEPTH = IDX_W'(MAX_LEN);

    logic [W-1:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wr_addr < DEPTH)) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // idx can sit at len == MAX_LEN once solved; that address is not backed by storage.
    assign rd_data  = (rd_addr < DEPTH) ? mem[rd_addr[AW-1:0]] : '0;
    assign rd0_data = mem[0];

endmodule

// File: rtl/seq_unlock_fsm.sv
// Purpose : programmable sequence matcher; raises sticky solved after cfg_len in-order symbol matches.
// Latency : 1 cycle from the final matching di beat to solved/idx update.
// Backpressure: none; one symbol consumed per di_valid beat, dropped when clear or a cfg write shares the cycle.
//
// Ports: clk, rst_n (sync active-low), clear (restart + unlock), cfg_we/cfg_addr/cfg_data
// (pattern write), cfg_len_we/cfg_len (length write, clamped to MAX_LEN), di_valid/di (symbol
// stream), idx (symbols matched), solved, locked, fail_cnt (saturating mismatch count).
module seq_unlock_fsm
    import seq_unlock_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int MAX_LEN   = DEF_MAX_LEN,
    parameter int IDX_W     = $clog2(MAX_LEN + 1),
    parameter int XOR_IDX   = 1,
    parameter int RESYNC    = 1,
    parameter int MAX_FAILS = 0,
    parameter int FAIL_W    = DEF_FAIL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [W-1:0]      cfg_data,
    input  logic              cfg_len_we,
    input  logic [IDX_W-1:0]  cfg_len,
    input  logic              di_valid,
    input  logic [W-1:0]      di,
    output logic [IDX_W-1:0]  idx,
    output logic              solved,
    output logic              locked,
    output logic [FAIL_W-1:0] fail_cnt
);

    localparam logic [IDX_W-1:0] DEPTH = IDX_W'(MAX_LEN);
    localparam logic [31:0]      MAXF  = 32'(MAX_FAILS);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  len_q, len_d, idx_d, len_wr;
    logic [FAIL_W-1:0] fail_d, fail_inc;
    logic [W-1:0]      pat_cur, pat_first, key;
    logic              cfg_any, match, resync_hit;

    // A cfg write that coincides with clear is discarded, so the store is gated here too.
    seq_unlock_pattern_mem #(
        .W       (W),
        .MAX_LEN (MAX_LEN),
        .IDX_W   (IDX_W)
    ) u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (cfg_we && !clear),
        .wr_addr  (cfg_addr),
        .wr_data  (cfg_data),
        .rd_addr  (idx),
        .rd_data  (pat_cur),
        .rd0_data (pat_first)
    );

    assign cfg_any    = cfg_we | cfg_len_we;
    assign len_wr     = (cfg_len > DEPTH) ? DEPTH : cfg_len;
    // The index is folded into the symbol so a replayed byte stream at the wrong offset never matches.
    assign key        = (XOR_IDX != 0) ? (di ^ W'(idx)) : di;
    assign match      = (key == pat_cur);
    // Resync compares the raw symbol: at index 0 the XOR term is zero anyway.
    assign resync_hit = (RESYNC != 0) && (di == pat_first);
    assign fail_inc   = (&fail_cnt) ? fail_cnt : fail_cnt + 1'b1;

    // State register (plus the index/length/fail datapath registers it owns)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_DISARMED;
            idx      <= '0;
            len_q    <= '0;
            fail_cnt <= '0;
        end else begin
            state_q  <= state_d;
            idx      <= idx_d;
            len_q    <= len_d;
            fail_cnt <= fail_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx;
        len_d   = len_q;
        fail_d  = fail_cnt;

        if (clear) begin
            idx_d   = '0;
            fail_d  = '0;
            state_d = (len_q == '0) ? ST_DISARMED : ST_ARMED;
        end else if (cfg_any) begin
            if (cfg_len_we) begin
                len_d = len_wr;
            end
            idx_d = '0;
            // Reprogramming does not lift a lockout; only clear or reset does.
            if (state_q != ST_LOCKED) begin
                state_d = (len_d == '0) ? ST_DISARMED : ST_ARMED;
            end
        end else if (di_valid && (state_q == ST_ARMED)) begin
            if (match) begin
                idx_d = idx + 1'b1;
                if (idx_d == len_q) begin
                    state_d = ST_SOLVED;
                end
            end else begin
                fail_d = fail_inc;
                if (resync_hit) begin
                    idx_d = IDX_W'(1);
                    if (len_q == IDX_W'(1)) begin
                        state_d = ST_SOLVED;
                    end
                end else begin
                    idx_d = '0;
                end
                if ((MAX_FAILS != 0) && (32'(fail_d) >= MAXF)) begin
                    state_d = ST_LOCKED;
                    idx_d   = '0;
                end
            end
        end
    end

    // Output decode
    always_comb begin
        solved = (state_q == ST_SOLVED);
        locked = (state_q == ST_LOCKED);
    end

endmodule

// File: tb/tb_seq_unlock_fsm.sv
// Purpose : checks seq_unlock_fsm (lockout off and MAX_FAILS=3) against a behavioural model.
// Latency : expected outputs are queued at each active edge and compared on the following falling edge.
// Backpressure: n/a.
module tb_seq_unlock_fsm;

    localparam int W       = 8;
    localparam int MAX_LEN = 64;
    localparam int IDX_W   = 7;
    localparam int FAIL_W  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, clear, cfg_we, cfg_len_we, di_valid;
    logic [IDX_W-1:0]  cfg_addr, cfg_len;
    logic [W-1:0]      cfg_data, di;
    logic [IDX_W-1:0]  idx0, idx1;
    logic              solved0, solved1, locked0, locked1;
    logic [FAIL_W-1:0] fail0, fail1;

    seq_unlock_fsm #(.MAX_FAILS(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
        .di_valid(di_valid), .di(di),
        .idx(idx0), .solved(solved0), .locked(locked0), .fail_cnt(fail0)
    );

    seq_unlock_fsm #(.MAX_FAILS(3)) u_dut_lk (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
        .di_valid(di_valid), .di(di),
        .idx(idx1), .solved(solved1), .locked(locked1), .fail_cnt(fail1)
    );

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic              solved;
        logic              locked;
        logic [FAIL_W-1:0] fail;
    } obs_t;

    obs_t exp_q0[$];
    obs_t exp_q1[$];
    obs_t e0, e1;
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: pattern array, length, and per-instance match count / fails / flags.
    logic [W-1:0] m_pat [MAX_LEN];
    int m_len;
    int m_idx    [2];
    int m_fail   [2];
    bit m_solved [2];
    bit m_locked [2];
    int m_maxf   [2] = '{0, 3};

    task automatic model_step();
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) m_pat[i] = '0;
            m_len = 0;
            for (int k = 0; k < 2; k++) begin
                m_idx[k] = 0; m_fail[k] = 0; m_solved[k] = 0; m_locked[k] = 0;
            end
        end else if (clear) begin
            for (int k = 0; k < 2; k++) begin
                m_idx[k] = 0; m_fail[k] = 0; m_solved[k] = 0; m_locked[k] = 0;
            end
        end else if (cfg_we || cfg_len_we) begin
            if (cfg_we && (int'(cfg_addr) < MAX_LEN)) m_pat[cfg_addr[5:0]] = cfg_data;
            if (cfg_len_we) m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
            for (int k = 0; k < 2; k++) begin
                m_idx[k] = 0; m_solved[k] = 0;
            end
        end else if (di_valid) begin
            for (int k = 0; k < 2; k++) begin
                if (m_len != 0 && !m_solved[k] && !m_locked[k]) begin
                    if ((di ^ 8'(m_idx[k])) == m_pat[m_idx[k][5:0]]) begin
                        m_idx[k]++;
                        if (m_idx[k] == m_len) m_solved[k] = 1;
                    end else begin
                        if (m_fail[k] < 255) m_fail[k]++;
                        m_idx[k] = (di == m_pat[0]) ? 1 : 0;
                        if (m_idx[k] == m_len) m_solved[k] = 1;
                        if (m_maxf[k] != 0 && m_fail[k] >= m_maxf[k]) begin
                            m_locked[k] = 1;
                            m_idx[k]    = 0;
                        end
                    end
                end
            end
        end
    endtask

    function automatic obs_t mobs(input int k);
        obs_t o;
        o.idx    = 7'(m_idx[k]);
        o.solved = m_solved[k];
        o.locked = m_locked[k];
        o.fail   = 8'(m_fail[k]);
        return o;
    endfunction

    task automatic cmp(input string who, input obs_t e, input obs_t g);
        if (g.idx !== e.idx) begin
            n_bad++; $display("FAIL %s idx: got %0d expected %0d", who, g.idx, e.idx);
        end
        if (g.solved !== e.solved) begin
            n_bad++; $display("FAIL %s solved: got %0b expected %0b", who, g.solved, e.solved);
        end
        if (g.locked !== e.locked) begin
            n_bad++; $display("FAIL %s locked: got %0b expected %0b", who, g.locked, e.locked);
        end
        if (g.fail !== e.fail) begin
            n_bad++; $display("FAIL %s fail_cnt: got %0d expected %0d", who, g.fail, e.fail);
        end
    endtask

    // Monitor: one queued expectation per applied cycle, checked on the falling edge.
    always @(negedge clk) begin
        if (exp_q0.size() > 0) begin
            e0 = exp_q0.pop_front();
            cmp("dut", e0, {idx0, solved0, locked0, fail0});
        end
        if (exp_q1.size() > 0) begin
            e1 = exp_q1.pop_front();
            cmp("dut_lk", e1, {idx1, solved1, locked1, fail1});
        end
    end

    task automatic step(input bit r, input bit c, input bit we, input int a, input int d,
                        input bit lwe, input int l, input bit v, input int x);
        rst_n = r; clear = c; cfg_we = we; cfg_addr = 7'(a); cfg_data = 8'(d);
        cfg_len_we = lwe; cfg_len = 7'(l); di_valid = v; di = 8'(x);
        @(posedge clk);
        model_step();
        exp_q0.push_back(mobs(0));
        exp_q1.push_back(mobs(1));
        n_vec++;
        #1;
    endtask

    task automatic beat(input int x);          step(1, 0, 0, 0, 0, 0, 0, 1, x); endtask
    task automatic idle();                     step(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_clear();                 step(1, 1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic wr(input int a, input int d); step(1, 0, 1, a, d, 0, 0, 0, 0); endtask
    task automatic set_len(input int l);       step(1, 0, 0, 0, 0, 1, l, 0, 0); endtask

    // Direct check of a DUT output against a hand-derived value.
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_bad++; $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        // Reset
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 8'h6A);
        @(negedge clk);
        chk("rst_idx", idx0, 0); chk("rst_solved", solved0, 0);
        chk("rst_locked", locked1, 0); chk("rst_fail", fail1, 0);

        // 1: basic match
        wr(0, 8'h6A); wr(1, 8'h74); wr(2, 8'h71); wr(3, 8'h77); set_len(4);
        beat(8'h6A); beat(8'h75); beat(8'h73);
        @(negedge clk);
        chk("t1_idx3", idx0, 3); chk("t1_not_yet", solved0, 0);
        beat(8'h74);
        @(negedge clk);
        chk("t1_idx4", idx0, 4); chk("t1_solved", solved0, 1);
        idle(); beat(8'h00);
        @(negedge clk);
        chk("t1_sticky", solved0, 1);

        // 2: mismatch and resync
        do_clear();
        beat(8'h6A); beat(8'h75); beat(8'h00);
        @(negedge clk);
        chk("t2_idx0", idx0, 0); chk("t2_fail1", fail0, 1);
        beat(8'h6A); beat(8'h75); beat(8'h6A);
        @(negedge clk);
        chk("t2_resync_idx", idx0, 1); chk("t2_fail2", fail0, 2);

        // 3: lockout on the MAX_FAILS=3 instance
        do_clear();
        beat(8'h00); beat(8'h00); beat(8'h00);
        @(negedge clk);
        chk("t3_locked", locked1, 1); chk("t3_fail3", fail1, 3); chk("t3_nolock", locked0, 0);
        beat(8'h6A); beat(8'h75); beat(8'h73); beat(8'h74);
        @(negedge clk);
        chk("t3_ignored", idx1, 0); chk("t3_other_solved", solved0, 1);
        do_clear();
        @(negedge clk);
        chk("t3_unlock", locked1, 0); chk("t3_fail_clr", fail1, 0);

        // 4: valid gaps
        beat(8'h6A); idle(); beat(8'h75); idle(); idle(); beat(8'h73); idle();
        @(negedge clk);
        chk("t4_hold", idx1, 3);
        beat(8'h74);
        @(negedge clk);
        chk("t4_solved", solved1, 1); chk("t4_idx", idx0, 4);

        // 5: cfg write beats di; clear drops solved
        do_clear();
        beat(8'h6A); beat(8'h75);
        step(1, 0, 1, 10, 8'h55, 0, 0, 1, 8'h73);
        @(negedge clk);
        chk("t5_drop", idx0, 0); chk("t5_armed", solved0, 0);
        beat(8'h6A); beat(8'h75); beat(8'h73); beat(8'h74);
        do_clear();
        @(negedge clk);
        chk("t5_clear", solved0, 0);

        // 6: full depth, then disarm
        for (int i = 0; i < MAX_LEN; i++) wr(i, $urandom_range(0, 255));
        set_len(100);
        for (int i = 0; i < MAX_LEN; i++) beat(int'(m_pat[i]) ^ i);
        @(negedge clk);
        chk("t6_idx64", idx0, 64); chk("t6_solved", solved0, 1);
        beat(8'h11);
        set_len(0);
        beat(8'h6A); beat(8'h22);
        @(negedge clk);
        chk("t6_disarm_idx", idx0, 0); chk("t6_disarm_solved", solved0, 0); chk("t6_fail", fail0, 0);

        // 7: fail counter saturation
        do_clear(); wr(0, 8'h6A); set_len(4);
        for (int i = 0; i < 300; i++) beat(8'h00);
        @(negedge clk);
        chk("t7_sat", fail0, 255); chk("t7_lk_fail", fail1, 3);

        // Random traffic, including same-cycle priority collisions
        do_clear(); set_len(3);
        for (int n = 0; n < 3000; n++) begin
            int r, x, l;
            r = $urandom_range(0, 999);
            l = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 64 : 100) : $urandom_range(0, 6);
            if (r < 2) begin
                step(0, 0, 0, 0, 0, 0, 0, 0, 0);
            end else if (r < 20) begin
                step(1, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 255),
                     $urandom_range(0, 1) == 1, l, $urandom_range(0, 1) == 1, $urandom_range(0, 255));
            end else if (r < 60) begin
                bit we, lwe;
                we  = $urandom_range(0, 1) == 1;
                lwe = !we || ($urandom_range(0, 3) == 0);
                step(1, 0, we, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 6),
                     $urandom_range(0, 255), lwe, l, $urandom_range(0, 1) == 1, $urandom_range(0, 255));
            end else begin
                if ($urandom_range(0, 1) == 0 && m_idx[0] < MAX_LEN)
                    x = int'(m_pat[m_idx[0][5:0]]) ^ m_idx[0];
                else if ($urandom_range(0, 5) == 0)
                    x = int'(m_pat[0]);
                else
                    x = $urandom_range(0, 255);
                step(1, 0, 0, 0, 0, 0, 0, $urandom_range(0, 3) != 0, x);
            end
        end

        idle();
        @(negedge clk);
        @(negedge clk);
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d/%0d expectations left, expected 0", exp_q0.size(), exp_q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
